stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_pkg.sv | 23 ++
 rtl/stream_demux_if.sv | 32 +++
 rtl/stream_demux_slot.sv | 54 +++++
 rtl/stream_demux.sv | 61 ++++++
 tb/tb_stream_demux.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and the channel-select decode helper.
// Revision 1.0
`default_nettype none

package stream_demux_pkg;

  localparam int NUM_CH     = 4;
  localparam int SEL_W      = 2;
  localparam int CNT_W      = 8;
  localparam int DEF_DATA_W = 4;
  localparam int SLOT_DEPTH = 2;
  localparam int OCC_W      = $clog2(SLOT_DEPTH + 1);

  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux_if.sv
// stream_demux_if: source-side beat offer plus the four per-channel sink streams.
// Revision 1.0
`default_nettype none

interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [CNT_W-1:0]         beat_cnt;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, beat_cnt
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, beat_cnt
  );

endinterface

`default_nettype wire

// File: rtl/stream_demux_slot.sv
// demux_slot: one DEPTH-entry shift FIFO; head is always entry 0.
// Revision 1.0
`default_nettype none

module demux_slot #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              push_eff;
  logic              pop_eff;
  logic [IW-1:0]     wr_idx;

  assign push_eff = push && (count != CW'(DEPTH));
  assign pop_eff  = pop && (count != '0);
  assign wr_idx   = IW'(count - CW'(pop_eff));
  // Entry 0 is not overwritten by the last pop, so an empty slot keeps showing it.
  assign head     = mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pop_eff) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (CW'(i + 1) < count) begin
            mem[i] <= mem[i + 1];
          end
        end
      end
      if (push_eff) begin
        mem[wr_idx] <= push_data;
      end
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// stream_demux: routes each accepted beat to one of four buffered output channels.
// Revision 1.0
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_demux_if.slave  bus
);

  logic                     accept;
  logic [NUM_CH-1:0]        push_en;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        valid;
  logic [NUM_CH*DATA_W-1:0] heads;
  logic [OCC_W-1:0]         occ [NUM_CH];
  logic [CNT_W-1:0]         cnt;

  // Ready looks only at the current occupancy, so a same-cycle pop never frees a slot early.
  assign bus.in_ready = ~full[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign push_en      = accept ? sel_decode(bus.in_sel) : '0;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      demux_slot #(
        .DATA_W (DATA_W),
        .DEPTH  (SLOT_DEPTH)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_en[k]),
        .push_data (bus.in_data),
        .pop       (bus.out_ready[k]),
        .head      (heads[k*DATA_W +: DATA_W]),
        .count     (occ[k])
      );
      assign full[k]  = (occ[k] == OCC_W'(SLOT_DEPTH));
      assign valid[k] = (occ[k] != '0);
    end
  endgenerate

  assign bus.out_data  = heads;
  assign bus.out_valid = valid;
  assign bus.beat_cnt  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed checks of routing, buffering, counting and reset.
// Revision 1.0
`default_nettype none

module tb_stream_demux;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  stream_demux_if #(.DATA_W(4)) bus ();

  stream_demux #(.DATA_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 4'h0;
    bus.out_ready = 4'b0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_one(input logic [1:0] sel, input logic [3:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_data !== 16'h0000 || bus.beat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h cnt=%0d, expected 0000/0000/0", bus.out_valid, bus.out_data, bus.beat_cnt);
    end
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready sel=%0d: in_ready=%b, expected 1", s, bus.in_ready);
      end
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 4'hA;
    #1;
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL no_bypass: out_valid=%b, expected 0000", bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 4'b0100 || bus.out_data[11:8] !== 4'hA || bus.beat_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_beat: valid=%b d2=%h cnt=%0d, expected 0100/a/1", bus.out_valid, bus.out_data[11:8], bus.beat_cnt);
    end
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_data[11:8] !== 4'hA) begin
      errors++;
      $display("FAIL empty_holds_last: valid=%b d2=%h, expected 0000/a", bus.out_valid, bus.out_data[11:8]);
    end
  endtask

  task automatic test_full();
    do_reset();
    push_one(2'd0, 4'h1);
    push_one(2'd0, 4'h2);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_data  = 4'h3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready ch0: in_ready=%b, expected 0", bus.in_ready);
    end
    bus.in_sel = 2'd1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL other_ready ch1: in_ready=%b, expected 1", bus.in_ready);
    end
    bus.in_sel    = 2'd0;
    bus.out_ready = 4'b0001;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_data[3:0] !== 4'h1) begin
      errors++;
      $display("FAIL full_pop_ready: in_ready=%b d0=%h, expected 0/1", bus.in_ready, bus.out_data[3:0]);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid[0] !== 1'b1 || bus.out_data[3:0] !== 4'h2 || bus.beat_cnt !== 8'd2) begin
      errors++;
      $display("FAIL pop_first: v0=%b d0=%h cnt=%0d, expected 1/2/2", bus.out_valid[0], bus.out_data[3:0], bus.beat_cnt);
    end
    step();
    bus.out_ready = 4'b0000;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_data[3:0] !== 4'h2) begin
      errors++;
      $display("FAIL pop_second: valid=%b d0=%h, expected 0000/2", bus.out_valid, bus.out_data[3:0]);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    push_one(2'd3, 4'h5);
    bus.out_ready = 4'b1000;
    push_one(2'd3, 4'h6);
    checks++;
    if (bus.out_valid !== 4'b1000 || bus.out_data[15:12] !== 4'h6) begin
      errors++;
      $display("FAIL push_pop: valid=%b d3=%h, expected 1000/6", bus.out_valid, bus.out_data[15:12]);
    end
    step();
    bus.out_ready = 4'b0000;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_data[15:12] !== 4'h6) begin
      errors++;
      $display("FAIL push_pop_occ1: valid=%b d3=%h, expected 0000/6", bus.out_valid, bus.out_data[15:12]);
    end
  endtask

  task automatic test_all_pop();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_one(2'(k), 4'(k));
      push_one(2'(k), 4'(k + 8));
    end
    checks++;
    if (bus.out_valid !== 4'b1111 || bus.out_data !== 16'h3210) begin
      errors++;
      $display("FAIL all_filled: valid=%b data=%h, expected 1111/3210", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 4'b1111;
    step();
    bus.out_ready = 4'b0000;
    checks++;
    if (bus.out_valid !== 4'b1111 || bus.out_data !== 16'hBA98) begin
      errors++;
      $display("FAIL all_pop: valid=%b data=%h, expected 1111/ba98", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_wrap();
    int not_ready;
    not_ready = 0;
    do_reset();
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_sel  = 2'(i % 4);
      bus.in_data = 4'(i);
      #1;
      if (bus.in_ready !== 1'b1) not_ready++;
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.beat_cnt !== 8'd0 || not_ready != 0) begin
      errors++;
      $display("FAIL wrap_256: cnt=%0d stalls=%0d, expected 0/0", bus.beat_cnt, not_ready);
    end
    push_one(2'd1, 4'h7);
    checks++;
    if (bus.beat_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wrap_257: cnt=%0d, expected 1", bus.beat_cnt);
    end
    bus.out_ready = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    push_one(2'd1, 4'hC);
    push_one(2'd1, 4'hD);
    push_one(2'd2, 4'hE);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.beat_cnt !== 8'd0 || bus.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: valid=%b cnt=%0d data=%h, expected 0000/0/0000", bus.out_valid, bus.beat_cnt, bus.out_data);
    end
    #2;
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_data !== 16'h0000 || bus.beat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL after_reset: valid=%b data=%h cnt=%0d, expected 0000/0000/0", bus.out_valid, bus.out_data, bus.beat_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_full();
    test_push_pop();
    test_all_pop();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
